auth_lock: RTL

Parametrised, clocked combination-lock authenticator for the auth datapath. It compares a CODE_W-bit guess against a stored code whenever the submit button is pressed, and reports the result as one-cycle matched/unmatched pulses. It counts consecutive failures and enters a timed lockout after MAX_TRIES misses. The stored code is reprogrammable only while the lock is open.

---
 rtl/auth_pkg.sv | 22 ++
 rtl/auth_edge_det.sv | 25 ++
 rtl/auth_lock.sv | 128 ++++++++++++
 3 files changed

// File: rtl/auth_pkg.sv
// Shared types and width helpers for the auth_lock combination-lock block.
// Imported by the top-level lock and its submit edge detector.
package auth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // Enough bits to hold every value from 0 up to and including max_tries.
  function automatic int tries_w(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // The lockout timer counts down from lock_cycles-1. A single-cycle
  // lockout still needs a one-bit register.
  function automatic int timer_w(input int lock_cycles);
    return (lock_cycles > 1) ? $clog2(lock_cycles) : 1;
  endfunction

endpackage

// File: rtl/auth_edge_det.sv
// Rising-edge detector for the submit button. The button level is assumed to
// be synchronous to clk already, so there is no synchroniser stage.
module auth_edge_det
  import auth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic sub_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, independent of the order the always blocks execute in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_q <= 1'b0;
    else        sub_q <= level;
  end

  // sub_q clears on reset, so a button that is already held when reset
  // releases still produces one press.
  assign press = level & ~sub_q;

endmodule

// File: rtl/auth_lock.sv
// Clocked combination lock. It compares a guess against a stored code on each
// submit press, counts consecutive misses and enters a timed lockout after
// MAX_TRIES misses. The code can be reprogrammed only while the lock is open.
module auth_lock
  import auth_pkg::*;
#(
  parameter int                CODE_W       = 4,
  parameter int                MAX_TRIES    = 3,
  parameter int                LOCK_CYCLES  = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          submit,
  input  logic [CODE_W-1:0]             guess,
  input  logic                          set_en,
  input  logic [CODE_W-1:0]             set_code,
  input  logic                          relock,
  output logic                          matched,
  output logic                          unmatched,
  output logic                          unlocked,
  output logic                          locked_out,
  output logic [tries_w(MAX_TRIES)-1:0] tries_left
);

  localparam int                  TRIES_W    = tries_w(MAX_TRIES);
  localparam int                  TIMER_W    = timer_w(LOCK_CYCLES);
  localparam logic [TRIES_W-1:0]  TRIES_MAX  = TRIES_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(LOCK_CYCLES - 1);

  state_t               state, state_nx;
  logic [CODE_W-1:0]    code, code_nx;
  logic [TRIES_W-1:0]   fail_cnt, fail_nx, fail_inc;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic                 matched_nx, unmatched_nx;
  logic                 press;

  auth_edge_det u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .level (submit),
    .press (press)
  );

  // NOTE: every variable written here gets a default before the case
  // statement, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    code_nx      = code;
    fail_nx      = fail_cnt;
    timer_nx     = timer;
    matched_nx   = 1'b0;
    unmatched_nx = 1'b0;
    fail_inc     = fail_cnt + TRIES_W'(1);

    unique case (state)
      IDLE: begin
        if (press) begin
          if (guess == code) begin
            matched_nx = 1'b1;
            fail_nx    = '0;
            state_nx   = OPEN;
          end else begin
            unmatched_nx = 1'b1;
            if (fail_inc == TRIES_MAX) begin
              fail_nx  = '0;
              timer_nx = TIMER_LOAD;
              state_nx = LOCKOUT;
            end else begin
              fail_nx = fail_inc;
            end
          end
        end
      end

      // Presses are ignored while open; a relock in the same cycle as
      // set_en still takes the new code.
      OPEN: begin
        if (set_en) code_nx  = set_code;
        if (relock) state_nx = IDLE;
      end

      // The timer is loaded with LOCK_CYCLES-1 and the exit happens on the
      // edge where it reads zero, which gives exactly LOCK_CYCLES cycles.
      LOCKOUT: begin
        if (timer == '0) state_nx = IDLE;
        else             timer_nx = timer - TIMER_W'(1);
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the code register is a single word, not a memory array, so it is
  // reset to DEFAULT_CODE along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= DEFAULT_CODE;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      state    <= state_nx;
      code     <= code_nx;
      fail_cnt <= fail_nx;
      timer    <= timer_nx;
    end
  end

  // Outputs are registered from next-state values, so they line up with the
  // state register and each result pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matched    <= 1'b0;
      unmatched  <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      tries_left <= TRIES_MAX;
    end else begin
      matched    <= matched_nx;
      unmatched  <= unmatched_nx;
      unlocked   <= (state_nx == OPEN);
      locked_out <= (state_nx == LOCKOUT);
      tries_left <= TRIES_MAX - fail_nx;
    end
  end

endmodule
